// File: rtl/mem_program_ram.sv
// Writable RV32E program memory: NOP sweep after reset, registered fetch port, runtime load port.
// Optional accepted-fetch counter port enabled by defining MEM_PROGRAM_FETCH_COUNT_EN.
module mem_program_ram #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 512,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_fault,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  init_done
`ifdef MEM_PROGRAM_FETCH_COUNT_EN
    ,
    output logic [31:0]           fetch_count
`endif
);

    localparam int unsigned   CW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   IW        = ADDR_WIDTH - 2;
    localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);
    localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);

    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fault_q, fault_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]         f_idx, l_idx;
    logic                  f_bad, l_ok, accept;
    logic                  mem_we;
    logic [CW-1:0]         mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign f_idx = fetch_addr[ADDR_WIDTH-1:2];
    assign l_idx = load_addr[ADDR_WIDTH-1:2];
    assign f_bad = (fetch_addr[1:0] != 2'b00) || (f_idx >= DEPTH_IDX);
    assign l_ok  = (load_addr[1:0] == 2'b00) && (l_idx < DEPTH_IDX);

    assign fetch_ready = (state_q == S_READY) && (!rsp_valid_q || rsp_ready);
    assign accept      = fetch_req && fetch_ready;

    assign rsp_valid   = rsp_valid_q;
    assign fetch_data  = data_q;
    assign fetch_fault = fault_q;
    assign init_done   = (state_q == S_READY);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        data_d      = data_q;
        fault_d     = fault_q;
        mem_we      = 1'b0;
        mem_widx    = cnt_q;
        mem_wdata   = NOP_WORD;

        if (state_q == S_INIT) begin
            // Sweep owns the write port; loads are ignored until it finishes.
            mem_we = 1'b1;
            if (cnt_q == LAST_IDX) begin
                state_d = S_READY;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (load_we && l_ok) begin
                mem_we    = 1'b1;
                mem_widx  = l_idx[CW-1:0];
                mem_wdata = load_data;
            end
            if (accept) begin
                rsp_valid_d = 1'b1;
                fault_d     = f_bad;
                data_d      = f_bad ? NOP_WORD : mem[f_idx[CW-1:0]];
            end else if (rsp_ready) begin
                rsp_valid_d = 1'b0;
            end
        end
    end

    // Array is deliberately not reset; the sweep provides its initial contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            data_q      <= NOP_WORD;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            data_q      <= data_d;
            fault_q     <= fault_d;
        end
    end

`ifdef MEM_PROGRAM_FETCH_COUNT_EN
    logic [31:0] fcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else if (accept) begin
            fcnt_q <= fcnt_q + 32'd1;
        end
    end

    assign fetch_count = fcnt_q;
`endif

endmodule

// File: tb/tb_mem_program_ram.sv
// Directed self-checking bench for mem_program_ram (DEPTH=512, NOP=0x00000013).
// Checks fetch_count as well when MEM_PROGRAM_FETCH_COUNT_EN is defined.
module tb_mem_program_ram;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] fetch_data;
    logic        fetch_fault;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        init_done;
`ifdef MEM_PROGRAM_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int total;
    int bad;

    mem_program_ram #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (512),
        .NOP_WORD   (32'h00000013)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .fetch_data  (fetch_data),
        .fetch_fault (fetch_fault),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .init_done   (init_done)
`ifdef MEM_PROGRAM_FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge just after rst_n is released; counts cycles until init_done.
    task automatic wait_init(output int cyc, output int rdy_seen);
        cyc = 0;
        rdy_seen = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (init_done !== 1'b1 && fetch_ready !== 1'b0) rdy_seen++;
        end while (init_done !== 1'b1 && cyc < 1000);
    endtask

    // Presents one request for one cycle; ends at the negedge after the accepting edge.
    task automatic fetch_once(input logic [31:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        fetch_req  = 1'b0;
    endtask

    task automatic test_reset();
        int cyc, rdy;
        rst_n      = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        rsp_ready  = 1'b1;
        load_we    = 1'b1;
        load_addr  = 32'h0;
        load_data  = 32'hBAD0BAD0;
        repeat (2) @(negedge clk);
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL reset_fetch_ready: got %b want 0", fetch_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (fetch_data !== NOP) begin bad++; $display("FAIL reset_fetch_data: got %h want %h", fetch_data, NOP); end
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fetch_fault: got %b want 0", fetch_fault); end
        rst_n = 1'b1;
        wait_init(cyc, rdy);
        load_we = 1'b0;
        total++; if (cyc != 512) begin bad++; $display("FAIL sweep_cycles: got %0d want 512", cyc); end
        total++; if (rdy != 0) begin bad++; $display("FAIL sweep_fetch_ready: got %0d cycles ready want 0", rdy); end
`ifdef MEM_PROGRAM_FETCH_COUNT_EN
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL count_after_init: got %0d want 0", fetch_count); end
`endif
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL ready_after_init: got %b want 1", fetch_ready); end
        @(negedge clk);
        fetch_req = 1'b0;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL first_fetch_valid: got %b want 1", rsp_valid); end
        total++; if (fetch_data !== NOP) begin bad++; $display("FAIL first_fetch_data: got %h want %h", fetch_data, NOP); end
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL first_fetch_fault: got %b want 0", fetch_fault); end
    endtask

    task automatic test_load();
        rsp_ready = 1'b1;
        load_we   = 1'b1;
        load_addr = 32'h4;
        load_data = 32'h00100093;
        @(negedge clk);
        load_we = 1'b0;
        fetch_once(32'h4);
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL load_valid: got %b want 1", rsp_valid); end
        total++; if (fetch_data !== 32'h00100093) begin bad++; $display("FAIL load_data: got %h want 00100093", fetch_data); end
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL load_fault: got %b want 0", fetch_fault); end
    endtask

    task automatic test_fault();
        logic [31:0] addrs [4];
        addrs[0] = 32'h2;
        addrs[1] = 32'h6;
        addrs[2] = 32'h800;
        addrs[3] = 32'h804;
        for (int i = 0; i < 4; i++) begin
            fetch_once(addrs[i]);
            total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL fault_flag[%h]: got %b want 1", addrs[i], fetch_fault); end
            total++; if (fetch_data !== NOP) begin bad++; $display("FAIL fault_data[%h]: got %h want %h", addrs[i], fetch_data, NOP); end
        end
        // Dropped writes: misaligned onto word 1, out of range aliasing word 0.
        load_we   = 1'b1;
        load_addr = 32'h6;
        load_data = 32'h11111111;
        @(negedge clk);
        load_addr = 32'h800;
        load_data = 32'hCAFEF00D;
        @(negedge clk);
        load_we = 1'b0;
        fetch_once(32'h4);
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL after_fault_flag: got %b want 0", fetch_fault); end
        total++; if (fetch_data !== 32'h00100093) begin bad++; $display("FAIL misaligned_load_dropped: got %h want 00100093", fetch_data); end
        fetch_once(32'h0);
        total++; if (fetch_data !== NOP) begin bad++; $display("FAIL range_load_dropped: got %h want %h", fetch_data, NOP); end
    endtask

    task automatic test_same_cycle();
        load_we    = 1'b1;
        load_addr  = 32'h8;
        load_data  = 32'hDEADBEEF;
        fetch_req  = 1'b1;
        fetch_addr = 32'h8;
        @(negedge clk);
        load_we   = 1'b0;
        fetch_req = 1'b0;
        total++; if (fetch_data !== NOP) begin bad++; $display("FAIL rbw_old: got %h want %h", fetch_data, NOP); end
        fetch_once(32'h8);
        total++; if (fetch_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rbw_new: got %h want deadbeef", fetch_data); end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        fetch_req = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", rsp_valid); end
        rsp_ready  = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        @(negedge clk);
        fetch_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b want 1", i, rsp_valid); end
            total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL hold_ready[%0d]: got %b want 0", i, fetch_ready); end
            total++; if (fetch_data !== NOP) begin bad++; $display("FAIL hold_data[%0d]: got %h want %h", i, fetch_data, NOP); end
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", fetch_ready); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || fetch_data !== 32'h00100093) begin bad++; $display("FAIL b2b_1: got v=%b %h want v=1 00100093", rsp_valid, fetch_data); end
        fetch_addr = 32'h8;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || fetch_data !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_2: got v=%b %h want v=1 deadbeef", rsp_valid, fetch_data); end
        fetch_req = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL consume_valid: got %b want 0", rsp_valid); end
        total++; if (fetch_data !== 32'hDEADBEEF) begin bad++; $display("FAIL consume_data_hold: got %h want deadbeef", fetch_data); end
    endtask

    task automatic test_reset_mid();
        int cyc, rdy;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL midsweep_init_done: got %b want 0", init_done); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(cyc, rdy);
        total++; if (cyc != 512) begin bad++; $display("FAIL midsweep_cycles: got %0d want 512", cyc); end
        fetch_once(32'h4);
        total++; if (fetch_data !== NOP) begin bad++; $display("FAIL resweep_data: got %h want %h", fetch_data, NOP); end
        load_we   = 1'b1;
        load_addr = 32'hC;
        load_data = 32'h12345678;
        @(negedge clk);
        load_we    = 1'b0;
        rsp_ready  = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'hC;
        @(negedge clk);
        fetch_req = 1'b0;
        total++; if (rsp_valid !== 1'b1 || fetch_data !== 32'h12345678) begin bad++; $display("FAIL pending_rsp: got v=%b %h want v=1 12345678", rsp_valid, fetch_data); end
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midtxn_valid: got %b want 0", rsp_valid); end
        total++; if (fetch_data !== NOP) begin bad++; $display("FAIL midtxn_data: got %h want %h", fetch_data, NOP); end
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL midtxn_init_done: got %b want 0", init_done); end
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        wait_init(cyc, rdy);
        total++; if (cyc != 512) begin bad++; $display("FAIL midtxn_cycles: got %0d want 512", cyc); end
`ifdef MEM_PROGRAM_FETCH_COUNT_EN
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL count_reset: got %0d want 0", fetch_count); end
`endif
        fetch_once(32'hC);
        total++; if (fetch_data !== NOP) begin bad++; $display("FAIL resweep_word3: got %h want %h", fetch_data, NOP); end
        fetch_once(32'h0);
        fetch_once(32'h2);
        fetch_once(32'h800);
        fetch_once(32'h4);
`ifdef MEM_PROGRAM_FETCH_COUNT_EN
        total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL count_five: got %0d want 5", fetch_count); end
`endif
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        rsp_ready  = 1'b1;
        load_we    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        #2;
        test_reset();
        test_load();
        test_fault();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_program_ram.md
Name: mem_program_ram

Overview:
- Parametrised, writable program memory replacing the fixed combinational program ROM for the RV32E core.
- Byte-addressed fetch port with valid/ready handshake and registered read data (1-cycle latency).
- Separate load port so a bootloader or testbench can write the program at runtime.
- After reset, a hardware sweep fills every word with NOP before any fetch is accepted.

Parameters:
- ADDR_WIDTH, 32, byte-address width of fetch_addr and load_addr.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 512, number of words; word index = addr >> 2.
- NOP_WORD, 32'h00000013, fill value and fault return value (ADDI x0, x0, 0).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_req  input  1  fetch request valid.
- fetch_addr  input  ADDR_WIDTH  byte address of the instruction.
- fetch_ready  output  1  request accepted this cycle when fetch_req=1.
- rsp_valid  output  1  fetch_data/fetch_fault valid.
- rsp_ready  input  1  consumer takes the response.
- fetch_data  output  DATA_WIDTH  instruction word.
- fetch_fault  output  1  misaligned or out-of-range fetch.
- load_we  input  1  write strobe.
- load_addr  input  ADDR_WIDTH  byte address for the write.
- load_data  input  DATA_WIDTH  word to write.
- init_done  output  1  NOP sweep complete.

Behaviour:
- Reset (async assert, sync release):
  - state=INIT, sweep counter=0.
  - init_done=0, fetch_ready=0, rsp_valid=0, fetch_data=NOP_WORD, fetch_fault=0.
  - Memory array is not reset.
- State INIT:
  - Each cycle writes NOP_WORD to word[counter], then counter increments.
  - At counter=DEPTH-1, the write completes and the next state is READY, so init_done=1 exactly DEPTH cycles after reset release.
  - fetch_ready=0 throughout; load_we is ignored.
- State READY: fetch_ready = !rsp_valid | rsp_ready (one-entry output register with pass-through on consume).
- Accept: fetch_req & fetch_ready.
  - On the next edge: rsp_valid=1.
  - fetch_data = mem[fetch_addr>>2]; fetch_fault=0.
- Fault:
  - Condition: fetch_addr[1:0]!=0, or (fetch_addr>>2) >= DEPTH.
  - Result: fetch_fault=1, fetch_data=NOP_WORD, memory not read.
  - Misalignment check takes precedence; both conditions give the same outputs.
- Output hold: while rsp_valid & !rsp_ready, fetch_data, fetch_fault and rsp_valid are held and no new request is accepted.
- Consume without a new accept: rsp_valid=0 on the next edge; fetch_data holds its last value.
- Back-to-back: a consume and an accept in the same cycle give a continuous rsp_valid=1 with new data. Sustained throughput is 1 fetch/cycle.
- Load (READY only):
  - load_we=1 with load_addr[1:0]==0 and in range writes the word on the edge.
  - Misaligned or out-of-range writes are silently dropped.
- Same-cycle fetch and load to the same word: the fetch returns the OLD word (read-before-write); the new value is visible from the following fetch.
- rst_n asserted mid-sweep or mid-transaction: immediate return to INIT; any pending response is discarded (rsp_valid=0); the sweep restarts from 0.
- No combinational path from fetch_addr to fetch_data.

Optional Feature:
- Macro: MEM_PROGRAM_FETCH_COUNT_EN.
- Defined:
  - Extra output port fetch_count, output, 32 bits: number of accepted fetches since reset, including faulting ones.
  - Resets to 0 and wraps from 32'hFFFFFFFF to 0.
  - Not incremented during INIT.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, DEPTH=512, fetch_req=1 held -> fetch_ready=0 for 512 cycles, init_done rises on cycle 512; first fetch of addr 0x0 returns 32'h00000013, fetch_fault=0.
- Load addr 0x4 = 32'h00100093, then fetch 0x4 with rsp_ready=1 -> rsp_valid=1 one cycle after accept, fetch_data=32'h00100093.
- Fetch 0x2, then fetch 0x800 (index 512) -> both give fetch_fault=1, fetch_data=32'h00000013; a subsequent fetch of 0x4 gives fault=0.
- Same cycle: load 0x8=32'hDEADBEEF and fetch 0x8 -> old value 32'h00000013; next fetch of 0x8 -> 32'hDEADBEEF.
- rsp_ready=0 for 3 cycles with fetch_req=1 -> fetch_ready=0, fetch_data stable; rsp_ready=1 -> back-to-back responses at 1/cycle for addresses 0x0,0x4,0x8.
- rst_n pulsed low at sweep counter=100 and again with rsp_valid=1 -> rsp_valid=0 immediately, init_done=0, full 512-cycle sweep repeats; with MEM_PROGRAM_FETCH_COUNT_EN defined, fetch_count=0 after reset and reads 5 after 5 accepts.
